eusci_baud_tick_gen: RTL and testbench
======================================

# eusci_baud_tick_gen

Parametrised, single-clock baud-rate generator for the eUSCI_A UART path. It replaces derived-clock generation with synchronous one-cycle tick strobes: a bit tick, a mid-bit tick and an oversample tick, all in the BRCLK domain. It adds a configurable prescaler width, a receiver resync input for start-bit alignment, and both TI-style modulation stages. It sits between the eUSCI register block (UCAxBRW/UCAxMCTLW fields) and the UART TX/RX shift engines.

## Interface
- CNT_W, 16, prescaler width; internal period arithmetic is CNT_W+1 bits
- BRCLK  in  1  baud source clock; all state updates on posedge
- RST  in  1  synchronous, active-high reset
- UCABEN  in  1  generator enable; low holds all state at reset values
- wUC0BRx  in  CNT_W  prescaler N; N=0 treated as N=1
- wUCBRFx  in  4  first-stage modulation select (oversampled mode)
- wUCBRSx  in  8  second-stage modulation pattern, MSB used first
- wUCOS16  in  1  1 = 16x oversampling mode, 0 = low-frequency mode
- Resync  in  1  one-cycle pulse from RX start-bit detector: restart bit timing
- SampleTick  out  1  one-cycle strobe per oversample period (oversampled mode only)
- HalfTick  out  1  one-cycle strobe at bit midpoint (RX sampling point)
- BitTick  out  1  one-cycle strobe at end of each bit period
- BitIdx  out  3  modulation bit index, increments after each BitTick

## Operation
- State: PreCnt (CNT_W+1), OsIdx (4), BitIdx (3). All reset to 0; all outputs 0 in reset.
- m2 = wUCBRSx[7-BitIdx]; m1 = BRF pattern bit [15-OsIdx], pattern per UCBRFx table (0x0000, 0x4000, 0x4001, 0x6001, 0x6003, 0x7003, 0x7007, 0x7807, 0x780F, 0x7C0F, 0x7C1F, 0x7E1F, 0x7E3F, 0x7F3F, 0x7F7F, 0x7FFF for F=0..F).
- Low-frequency mode (wUCOS16=0): period P = N + m2. PreCnt counts 0..P-1; at PreCnt>=P-1: BitTick=1, PreCnt<=0, BitIdx<=BitIdx+1. HalfTick=1 when PreCnt==(P>>1)-1, or together with BitTick when P==1. SampleTick is held at 0.
- Oversampled mode (wUCOS16=1): sample period S = N + m1 + (m2 when OsIdx==15). At PreCnt>=S-1: SampleTick=1, PreCnt<=0, OsIdx<=OsIdx+1. BitTick=1 on the SampleTick where OsIdx==15; BitIdx then increments. HalfTick=1 on the SampleTick where OsIdx==7.
- Terminal compare is >= so a shrink of N or mode change mid-period wraps on the next cycle. It never counts through 2^(CNT_W+1).
- Resync=1 with UCABEN=1: PreCnt, OsIdx and BitIdx are set to 0 next edge. All ticks are suppressed in that cycle. Resync has priority over any wrap.
- UCABEN=0: state is cleared synchronously each cycle and all ticks are 0. Priority order: RST > UCABEN=0 > Resync > count.

## Timing
- Ticks are combinational decodes of registered state, so there is zero extra latency. They are glitch-free relative to BRCLK and high for exactly one cycle.
- Let k=0 be the first cycle with UCABEN=1, RST=0, Resync=0 after release or Resync. The first BitTick is in cycle k=P-1 (LF mode) or after 16 sample periods minus one (OS16 mode). Later BitTicks follow at the modulated period.
- Register-field changes take effect on the current count immediately. The modulation index for m1/m2 uses the current OsIdx/BitIdx.
- BitIdx wraps 7->0. OsIdx wraps 15->0.

## Configuration
- EUSCI_BRG_MOD2_EN defined: second-stage modulation (m2, BitIdx sequencing of wUCBRSx) is compiled in.
- Not defined: m2 is forced to 0. wUCBRSx is ignored. BitIdx still counts, for the RX/TX engines. Bit period is exactly N (LF) or the sum of 16 m1-modulated samples (OS16).

## Test plan
- LF, N=4, BRS=0x00: BitTick at k=3,7,11,15; HalfTick at k=1,5,9. SampleTick stays 0.
- LF, N=4, BRS=0x80 (MOD2_EN): first bit is 5 cycles (BitTick k=4), then 4-cycle bits (k=8,12,…). The 9th bit is again 5 cycles.
- OS16, N=1, BRF=0, BRS=0: SampleTick every cycle; HalfTick at k=7; BitTick at k=15,31.
- OS16, N=2, BRF=1: sample period 3 at OsIdx=1, otherwise 2. Bit is 33 cycles, so BitTick is at k=32.
- Resync pulse at k=10 in LF N=8: no tick at k=10. The next BitTick comes 8 cycles after Resync deasserts, and HalfTick 4 cycles after. BitIdx reads 0.
- N=0 treated as 1 (LF): BitTick and HalfTick every cycle. UCABEN dropped mid-bit: all ticks are 0 next cycle and state is 0. Re-enable restarts from k=0. RST mid-bit gives the same result.

Source files
------------

// File: rtl/eusci_baud_tick_gen.sv
// eusci_baud_tick_gen
// Single-clock baud-rate generator for the eUSCI_A UART path. It produces
// one-cycle strobes in the BRCLK domain: an oversample tick, a mid-bit tick
// and an end-of-bit tick, plus the modulation bit index used by the shift
// engines.
//
// Optional feature macro: EUSCI_BRG_MOD2_EN
//    defined     - second-stage modulation (wUCBRSx indexed by BitIdx) adds
//                  one extra cycle to selected bit periods.
//    not defined - second-stage modulation contributes nothing and wUCBRSx
//                  is ignored; BitIdx still counts for the shift engines.
module eusci_baud_tick_gen #(
   parameter int CNT_W = 16
) (
   input  logic             BRCLK,
   input  logic             RST,
   input  logic             UCABEN,
   input  logic [CNT_W-1:0] wUC0BRx,
   input  logic [3:0]       wUCBRFx,
   input  logic [7:0]       wUCBRSx,
   input  logic             wUCOS16,
   input  logic             Resync,
   output logic             SampleTick,
   output logic             HalfTick,
   output logic             BitTick,
   output logic [2:0]       BitIdx
);

   // Period arithmetic needs one extra bit: N plus two modulation cycles
   // can exceed the prescaler range.
   localparam int PW = CNT_W + 1;
   localparam logic [PW-1:0] ONE  = PW'(1);
   localparam logic [PW-1:0] ZERO = '0;

   // Registered state
   logic [PW-1:0] pre_cnt_q;
   logic [PW-1:0] pre_cnt_d;
   logic [3:0]    os_idx_q;
   logic [3:0]    os_idx_d;
   logic [2:0]    bit_idx_q;
   logic [2:0]    bit_idx_d;

   // Modulation and period terms
   logic [15:0]   brf_pat;
   logic          m1;
   logic          m2;
   logic          m2_os;
   logic [PW-1:0] n_eff;
   logic [PW-1:0] lf_period;
   logic [PW-1:0] os_period;
   logic [PW-1:0] lf_last;
   logic [PW-1:0] os_last;
   logic [PW-1:0] lf_mid;

   // Decoded conditions
   logic          run;
   logic          lf_wrap;
   logic          lf_half;
   logic          os_wrap;
   logic          os_at_mid;
   logic          os_at_end;

   // First-stage modulation patterns, one per UCBRFx value. Bit 15 is
   // consumed at OsIdx 0, bit 0 at OsIdx 15.
   function automatic logic [15:0] brf_lookup(input logic [3:0] sel);
      logic [15:0] pat;
      pat = 16'h0000;
      case (sel)
         4'h0:    pat = 16'h0000;
         4'h1:    pat = 16'h4000;
         4'h2:    pat = 16'h4001;
         4'h3:    pat = 16'h6001;
         4'h4:    pat = 16'h6003;
         4'h5:    pat = 16'h7003;
         4'h6:    pat = 16'h7007;
         4'h7:    pat = 16'h7807;
         4'h8:    pat = 16'h780F;
         4'h9:    pat = 16'h7C0F;
         4'hA:    pat = 16'h7C1F;
         4'hB:    pat = 16'h7E1F;
         4'hC:    pat = 16'h7E3F;
         4'hD:    pat = 16'h7F3F;
         4'hE:    pat = 16'h7F7F;
         4'hF:    pat = 16'h7FFF;
         default: pat = 16'h0000;
      endcase
      return pat;
   endfunction

`ifdef EUSCI_BRG_MOD2_EN
   // Second-stage modulation: the BRS pattern is walked MSB first, one bit
   // per bit period, so BitIdx 0 selects wUCBRSx[7].
   always_comb begin
      m2 = wUCBRSx[3'd7 - bit_idx_q];
   end
`else
   // Second-stage modulation compiled out; the pattern input is only
   // reduced here so the unused port stays visibly consumed.
   logic unused_brs;

   always_comb begin
      m2         = 1'b0;
      unused_brs = ^wUCBRSx;
   end
`endif

   // First-stage modulation bit for the current oversample slot.
   always_comb begin
      brf_pat = brf_lookup(wUCBRFx);
      m1      = brf_pat[4'd15 - os_idx_q];
   end

   // Bit and sample periods from the live register fields; N=0 behaves as
   // N=1 so the counter always has a reachable terminal value.
   always_comb begin
      n_eff = {1'b0, wUC0BRx};
      if (wUC0BRx == '0) begin
         n_eff = ONE;
      end
      m2_os     = m2 & (os_idx_q == 4'd15);
      lf_period = n_eff + {{(PW-1){1'b0}}, m2};
      os_period = n_eff + {{(PW-1){1'b0}}, m1} + {{(PW-1){1'b0}}, m2_os};
      lf_last   = lf_period - ONE;
      os_last   = os_period - ONE;
      lf_mid    = (lf_period >> 1) - ONE;
   end

   // Terminal and midpoint decodes. The >= compare lets a shrinking period
   // wrap on the very next cycle instead of running the counter around.
   always_comb begin
      run       = UCABEN & ~RST & ~Resync;
      lf_wrap   = (pre_cnt_q >= lf_last);
      lf_half   = (lf_period == ONE) ? lf_wrap : (pre_cnt_q == lf_mid);
      os_wrap   = (pre_cnt_q >= os_last);
      os_at_mid = (os_idx_q == 4'd7);
      os_at_end = (os_idx_q == 4'd15);
   end

   // Tick outputs: combinational decode of registered state, forced low
   // whenever the generator is disabled, in reset or being resynchronised.
   always_comb begin
      SampleTick = 1'b0;
      HalfTick   = 1'b0;
      BitTick    = 1'b0;
      if (run) begin
         if (wUCOS16) begin
            SampleTick = os_wrap;
            HalfTick   = os_wrap & os_at_mid;
            BitTick    = os_wrap & os_at_end;
         end else begin
            HalfTick   = lf_half;
            BitTick    = lf_wrap;
         end
      end
   end

   // Next-state: disable and resync both clear all timing state; otherwise
   // count toward the active terminal and advance the indices on a wrap.
   always_comb begin
      pre_cnt_d = pre_cnt_q;
      os_idx_d  = os_idx_q;
      bit_idx_d = bit_idx_q;
      if (!UCABEN || Resync) begin
         pre_cnt_d = ZERO;
         os_idx_d  = 4'd0;
         bit_idx_d = 3'd0;
      end else if (wUCOS16) begin
         if (os_wrap) begin
            pre_cnt_d = ZERO;
            os_idx_d  = os_idx_q + 4'd1;
            if (os_at_end) begin
               bit_idx_d = bit_idx_q + 3'd1;
            end
         end else begin
            pre_cnt_d = pre_cnt_q + ONE;
         end
      end else begin
         if (lf_wrap) begin
            pre_cnt_d = ZERO;
            bit_idx_d = bit_idx_q + 3'd1;
         end else begin
            pre_cnt_d = pre_cnt_q + ONE;
         end
      end
   end

   // State registers with synchronous active-high reset.
   always_ff @(posedge BRCLK) begin
      if (RST) begin
         pre_cnt_q <= ZERO;
         os_idx_q  <= 4'd0;
         bit_idx_q <= 3'd0;
      end else begin
         pre_cnt_q <= pre_cnt_d;
         os_idx_q  <= os_idx_d;
         bit_idx_q <= bit_idx_d;
      end
   end

   // The bit index is architectural state visible to the shift engines.
   always_comb begin
      BitIdx = bit_idx_q;
   end

endmodule

// File: tb/tb_eusci_baud_tick_gen.sv
// Testbench for eusci_baud_tick_gen: directed scenarios with literal tick
// positions plus a randomized run, all cross-checked every cycle against a
// cycle-elapsed reference model.
module tb_eusci_baud_tick_gen;

   localparam int CNT_W = 16;
`ifdef EUSCI_BRG_MOD2_EN
   localparam bit MOD2 = 1'b1;
`else
   localparam bit MOD2 = 1'b0;
`endif

   logic             BRCLK = 1'b0;
   logic             RST;
   logic             UCABEN;
   logic [CNT_W-1:0] wUC0BRx;
   logic [3:0]       wUCBRFx;
   logic [7:0]       wUCBRSx;
   logic             wUCOS16;
   logic             Resync;
   logic             SampleTick;
   logic             HalfTick;
   logic             BitTick;
   logic [2:0]       BitIdx;

   int checks = 0;
   int errors = 0;
   bit modelOn = 1'b0;

   // Reference model state: cycles elapsed in the current period, current
   // oversample slot and current bit number.
   int mElapsed = 0;
   int mOs = 0;
   int mBit = 0;

   // Recorded outputs of the latest directed run, indexed by k.
   bit recB[64];
   bit recH[64];
   bit recS[64];
   int recIdx[64];

   int brfTable[16] = '{32'h0000, 32'h4000, 32'h4001, 32'h6001,
                        32'h6003, 32'h7003, 32'h7007, 32'h7807,
                        32'h780F, 32'h7C0F, 32'h7C1F, 32'h7E1F,
                        32'h7E3F, 32'h7F3F, 32'h7F7F, 32'h7FFF};

   eusci_baud_tick_gen #(.CNT_W(CNT_W)) dut (
      .BRCLK      (BRCLK),
      .RST        (RST),
      .UCABEN     (UCABEN),
      .wUC0BRx    (wUC0BRx),
      .wUCBRFx    (wUCBRFx),
      .wUCBRSx    (wUCBRSx),
      .wUCOS16    (wUCOS16),
      .Resync     (Resync),
      .SampleTick (SampleTick),
      .HalfTick   (HalfTick),
      .BitTick    (BitTick),
      .BitIdx     (BitIdx)
   );

   // Free-running baud source clock.
   always #5 BRCLK = ~BRCLK;

   task automatic checkOutput(input string name, input int actual, input int expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s got %0d expected %0d at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic applyStimulus(input logic en, input logic rst, input logic rs,
                                input logic os16, input int n, input int f, input int s);
      UCABEN  = en;
      RST     = rst;
      Resync  = rs;
      wUCOS16 = os16;
      wUC0BRx = CNT_W'(n);
      wUCBRFx = 4'(f);
      wUCBRSx = 8'(s);
   endtask

   // Reset for one cycle, then enable with the given fields; the next cycle
   // is k=0.
   task automatic restart(input logic os16, input int n, input int f, input int s);
      applyStimulus(1'b0, 1'b1, 1'b0, os16, n, f, s);
      @(posedge BRCLK);
      #1;
      applyStimulus(1'b1, 1'b0, 1'b0, os16, n, f, s);
   endtask

   task automatic runRecord(input int len);
      for (int k = 0; k < len; k++) begin
         @(negedge BRCLK);
         recB[k]   = BitTick;
         recH[k]   = HalfTick;
         recS[k]   = SampleTick;
         recIdx[k] = int'(BitIdx);
         @(posedge BRCLK);
         #1;
      end
   endtask

   // kind: 0 BitTick, 1 HalfTick, 2 SampleTick. Returns k of nth hit or -1.
   function automatic int nthTick(input int kind, input int nth, input int len);
      int seen;
      bit hit;
      seen = 0;
      for (int k = 0; k < len; k++) begin
         hit = (kind == 0) ? recB[k] : (kind == 1) ? recH[k] : recS[k];
         if (hit) begin
            seen++;
            if (seen == nth) return k;
         end
      end
      return -1;
   endfunction

   function automatic int countTicks(input int kind, input int len);
      int seen;
      seen = 0;
      for (int k = 0; k < len; k++) begin
         if ((kind == 0 && recB[k]) || (kind == 1 && recH[k]) || (kind == 2 && recS[k])) begin
            seen++;
         end
      end
      return seen;
   endfunction

   // Reference model: each cycle, derive the period from the current fields
   // and the elapsed count, compare all outputs, then advance.
   always @(negedge BRCLK) begin : refModel
      int n;
      int m1;
      int m2;
      int period;
      int expS;
      int expH;
      int expB;
      int nElapsed;
      int nOs;
      int nBit;
      if (modelOn) begin
         expS = 0;
         expH = 0;
         expB = 0;
         nElapsed = mElapsed;
         nOs = mOs;
         nBit = mBit;
         if (RST || !UCABEN || Resync) begin
            nElapsed = 0;
            nOs = 0;
            nBit = 0;
         end else begin
            n = (int'(wUC0BRx) == 0) ? 1 : int'(wUC0BRx);
            m2 = MOD2 ? ((int'(wUCBRSx) >> (7 - mBit)) & 1) : 0;
            if (!wUCOS16) begin
               period = n + m2;
               expB = (mElapsed + 1 >= period) ? 1 : 0;
               if (period == 1) expH = expB;
               else expH = (mElapsed == period / 2 - 1) ? 1 : 0;
               if (expB == 1) begin
                  nElapsed = 0;
                  nBit = (mBit + 1) % 8;
               end else begin
                  nElapsed = mElapsed + 1;
               end
            end else begin
               m1 = (brfTable[int'(wUCBRFx)] >> (15 - mOs)) & 1;
               period = n + m1 + ((mOs == 15) ? m2 : 0);
               expS = (mElapsed + 1 >= period) ? 1 : 0;
               expH = (expS == 1 && mOs == 7) ? 1 : 0;
               expB = (expS == 1 && mOs == 15) ? 1 : 0;
               if (expS == 1) begin
                  nElapsed = 0;
                  nOs = (mOs + 1) % 16;
                  if (expB == 1) nBit = (mBit + 1) % 8;
               end else begin
                  nElapsed = mElapsed + 1;
               end
            end
         end
         checkOutput("model SampleTick", int'(SampleTick), expS);
         checkOutput("model HalfTick", int'(HalfTick), expH);
         checkOutput("model BitTick", int'(BitTick), expB);
         checkOutput("model BitIdx", int'(BitIdx), mBit);
         mElapsed = nElapsed;
         mOs = nOs;
         mBit = nBit;
      end
   end

   // Directed scenarios followed by randomized stimulus.
   initial begin
      logic os16;
      int n;
      int f;
      int s;
      int en;
      int rst;
      int rs;
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 4, 0, 0);
      @(posedge BRCLK);
      #1;
      modelOn = 1'b1;

      // Reset state
      runRecord(1);
      checkOutput("reset BitTick", int'(recB[0]), 0);
      checkOutput("reset HalfTick", int'(recH[0]), 0);
      checkOutput("reset BitIdx", recIdx[0], 0);

      // LF N=4 no modulation
      restart(1'b0, 4, 0, 0);
      runRecord(16);
      checkOutput("lf4 bit1", nthTick(0, 1, 16), 3);
      checkOutput("lf4 bit4", nthTick(0, 4, 16), 15);
      checkOutput("lf4 bitcount", countTicks(0, 16), 4);
      checkOutput("lf4 half1", nthTick(1, 1, 16), 1);
      checkOutput("lf4 half3", nthTick(1, 3, 16), 9);
      checkOutput("lf4 samplecount", countTicks(2, 16), 0);
      checkOutput("lf4 idx k4", recIdx[4], 1);

      // LF N=4 with BRS=0x80
      restart(1'b0, 4, 0, 8'h80);
      runRecord(40);
      checkOutput("lfmod bit1", nthTick(0, 1, 40), MOD2 ? 4 : 3);
      checkOutput("lfmod bit2", nthTick(0, 2, 40), MOD2 ? 8 : 7);
      checkOutput("lfmod bit9", nthTick(0, 9, 40), MOD2 ? 37 : 35);

      // OS16 N=1 BRF=0
      restart(1'b1, 1, 0, 0);
      runRecord(34);
      checkOutput("os1 samplecount", countTicks(2, 34), 34);
      checkOutput("os1 half1", nthTick(1, 1, 34), 7);
      checkOutput("os1 bit1", nthTick(0, 1, 34), 15);
      checkOutput("os1 bit2", nthTick(0, 2, 34), 31);
      checkOutput("os1 idx k16", recIdx[16], 1);

      // OS16 N=2 BRF=1: one 3-cycle sample at OsIdx 1
      restart(1'b1, 2, 1, 0);
      runRecord(40);
      checkOutput("os2 half1", nthTick(1, 1, 40), 16);
      checkOutput("os2 bit1", nthTick(0, 1, 40), 32);
      checkOutput("os2 sample2", nthTick(2, 2, 40), 4);

      // Resync at k=10 in LF N=8
      restart(1'b0, 8, 0, 0);
      runRecord(10);
      checkOutput("rs idx before", recIdx[9], 1);
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 8, 0, 0);
      runRecord(1);
      checkOutput("rs cycle ticks", int'(recB[0]) + int'(recH[0]) + int'(recS[0]), 0);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8, 0, 0);
      runRecord(9);
      checkOutput("rs idx after", recIdx[0], 0);
      checkOutput("rs bit1", nthTick(0, 1, 9), 7);
      checkOutput("rs half1", nthTick(1, 1, 9), 3);

      // N=0 treated as N=1
      restart(1'b0, 0, 0, 0);
      runRecord(4);
      checkOutput("n0 bitcount", countTicks(0, 4), 4);
      checkOutput("n0 halfcount", countTicks(1, 4), 4);

      // UCABEN dropped mid-bit
      restart(1'b0, 8, 0, 0);
      runRecord(10);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 8, 0, 0);
      runRecord(2);
      checkOutput("dis ticks", int'(recB[0]) + int'(recH[0]), 0);
      checkOutput("dis idx", recIdx[1], 0);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8, 0, 0);
      runRecord(8);
      checkOutput("dis reenable bit1", nthTick(0, 1, 8), 7);

      // RST mid-bit
      restart(1'b0, 8, 0, 0);
      runRecord(10);
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 8, 0, 0);
      runRecord(1);
      checkOutput("rst ticks", int'(recB[0]) + int'(recH[0]), 0);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8, 0, 0);
      runRecord(8);
      checkOutput("rst idx", recIdx[0], 0);
      checkOutput("rst bit1", nthTick(0, 1, 8), 7);

      // Randomized run with live field changes, resyncs, disables and resets
      os16 = 1'b1;
      n = 1;
      f = 0;
      s = 0;
      for (int c = 0; c < 4000; c++) begin
         if ($urandom_range(39, 0) == 0) begin
            os16 = 1'($urandom_range(1, 0));
            n = ($urandom_range(3, 0) == 0) ? int'($urandom_range(12, 0)) : int'($urandom_range(4, 0));
            f = int'($urandom_range(15, 0));
            s = int'($urandom_range(255, 0));
         end
         rs  = ($urandom_range(59, 0) == 0) ? 1 : 0;
         en  = ($urandom_range(99, 0) != 0) ? 1 : 0;
         rst = ($urandom_range(299, 0) == 0) ? 1 : 0;
         applyStimulus(1'(en), 1'(rst), 1'(rs), os16, n, f, s);
         @(posedge BRCLK);
         #1;
      end

      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1, 0, 0);
      @(posedge BRCLK);
      #1;
      modelOn = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
